// File: rtl/mdu_issue_ctrl_pkg.sv
// mdu_issue_ctrl_pkg: shared codes for the multiply/divide issue controller.
// Holds the ID/EX mdop request codes, the mdu_op encodings, HI/LO select values,
// FSM state encoding and the decoded-request struct.
package mdu_issue_ctrl_pkg;
  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MADD  = 4'd5,
    MDOP_MTHI  = 4'd6,
    MDOP_MTLO  = 4'd7,
    MDOP_MFHI  = 4'd8,
    MDOP_MFLO  = 4'd9
  } mdop_e;
  typedef enum logic [1:0] {
    MDU_OP_MULTU = 2'b00,
    MDU_OP_MULT  = 2'b01,
    MDU_OP_DIVU  = 2'b10,
    MDU_OP_DIV   = 2'b11
  } mdu_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;
  localparam logic HILO_HI = 1'b0;
  localparam logic HILO_LO = 1'b1;
  typedef struct packed {
    logic    is_compute;
    logic    is_mt;
    logic    is_mf;
    mdu_op_e op;
    logic    madd;
    logic    hilo;
  } dec_t;
endpackage

// File: rtl/mdu_issue_ctrl_decode.sv
// mdu_issue_ctrl_decode: combinational decode of the ID/EX mdop field.
// Ports: mdop_i (4-bit request code) -> dec_o {is_compute, is_mt, is_mf, op, madd, hilo}.
// hilo selects LO for both MTLO and MFLO so the same bit drives the write target and the read mux.
module mdu_issue_ctrl_decode
  import mdu_issue_ctrl_pkg::*;
(
  input  logic [3:0] mdop_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o.is_compute = mdop_i inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU, MDOP_MADD};
    dec_o.is_mt      = mdop_i inside {MDOP_MTHI, MDOP_MTLO};
    dec_o.is_mf      = mdop_i inside {MDOP_MFHI, MDOP_MFLO};
    dec_o.op         = (mdop_i == MDOP_DIV)   ? MDU_OP_DIV :
                       (mdop_i == MDOP_DIVU)  ? MDU_OP_DIVU :
                       (mdop_i == MDOP_MULTU) ? MDU_OP_MULTU : MDU_OP_MULT;
    dec_o.madd       = mdop_i == MDOP_MADD;
    dec_o.hilo       = (mdop_i inside {MDOP_MTLO, MDOP_MFLO}) ? HILO_LO : HILO_HI;
  end
endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: EX-stage front end of the multiply/divide unit.
// Inputs : clk, rst (async, active-high), id_valid_i/id_mdop_i/id_rs_i/id_rt_i from ID/EX,
//          flush_i, mdu_busy_i, mdu_hi_i, mdu_lo_i.
// Outputs: registered issue interface mdu_d1_o/mdu_d2_o/mdu_op_o/mdu_start_o/mdu_madd_o/
//          mdu_we_o/mdu_hilo_o; combinational stall_o, mf_data_o, mf_valid_o; sticky timeout_o.
// FSM IDLE -> ARM (one-cycle start/we pulse) -> WAIT (until mdu_busy_i drops) -> IDLE.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [3:0]       id_mdop_i,
  input  logic [WIDTH-1:0] id_rs_i,
  input  logic [WIDTH-1:0] id_rt_i,
  input  logic             flush_i,
  input  logic             mdu_busy_i,
  input  logic [WIDTH-1:0] mdu_hi_i,
  input  logic [WIDTH-1:0] mdu_lo_i,
  output logic [WIDTH-1:0] mdu_d1_o,
  output logic [WIDTH-1:0] mdu_d2_o,
  output logic [1:0]       mdu_op_o,
  output logic             mdu_start_o,
  output logic             mdu_madd_o,
  output logic             mdu_we_o,
  output logic             mdu_hilo_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic             mf_valid_o,
  output logic             timeout_o
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  state_e           state_q, state_d;
  dec_t             dec;
  logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
  mdu_op_e          op_q, op_d;
  logic             start_q, start_d, madd_q, madd_d, we_q, we_d, hilo_q, hilo_d;
  logic             tmo_q, tmo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req, idle, accept;
  mdu_issue_ctrl_decode u_decode (
    .mdop_i (id_mdop_i),
    .dec_o  (dec)
  );
  assign req    = id_valid_i & ~flush_i;
  assign idle   = state_q == ST_IDLE;
  assign accept = req & (dec.is_compute | dec.is_mt) & idle;
  assign stall_o    = req & (dec.is_compute | dec.is_mt | dec.is_mf) & ~idle;
  assign mf_valid_o = req & dec.is_mf & idle;
  assign mf_data_o  = mf_valid_o ? (dec.hilo ? mdu_lo_i : mdu_hi_i) : '0;
  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    op_d    = op_q;
    start_d = start_q;
    madd_d  = madd_q;
    we_d    = we_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        d1_d    = id_rs_i;
        d2_d    = id_rt_i;
        op_d    = dec.op;
        hilo_d  = dec.hilo;
        start_d = dec.is_compute;
        madd_d  = dec.is_compute & dec.madd;
        we_d    = dec.is_mt;
        state_d = ST_ARM;
      end
      // busy is not consulted here: the mdu only raises it after sampling start
      ST_ARM: begin
        start_d = 1'b0;
        madd_d  = 1'b0;
        we_d    = 1'b0;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d   = (cnt_q == CW'(WAIT_MAX)) ? cnt_q : cnt_q + 1'b1;
        tmo_d   = tmo_q | (cnt_q == CW'(WAIT_MAX - 1));
        state_d = mdu_busy_i ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d1_q    <= '0;
      d2_q    <= '0;
      op_q    <= MDU_OP_MULTU;
      start_q <= 1'b0;
      madd_q  <= 1'b0;
      we_q    <= 1'b0;
      hilo_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      op_q    <= op_d;
      start_q <= start_d;
      madd_q  <= madd_d;
      we_q    <= we_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  assign mdu_d1_o    = d1_q;
  assign mdu_d2_o    = d2_q;
  assign mdu_op_o    = op_q;
  assign mdu_start_o = start_q;
  assign mdu_madd_o  = madd_q;
  assign mdu_we_o    = we_q;
  assign mdu_hilo_o  = hilo_q;
  assign timeout_o   = tmo_q;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: table vectors, directed sequences and random stimulus against a cycle-count reference model.
module tb_mdu_issue_ctrl;
  localparam int INF = 32'h7fffffff;
  logic        clk = 1'b0, rst;
  logic        id_valid, flush, mdu_busy;
  logic [3:0]  id_mdop;
  logic [31:0] id_rs, id_rt, mdu_hi, mdu_lo;
  logic [31:0] mdu_d1, mdu_d2, mf_data;
  logic [1:0]  mdu_op;
  logic        mdu_start, mdu_madd, mdu_we, mdu_hilo, stall, mf_valid, timeout;
  always #5 clk = ~clk;
  mdu_issue_ctrl #(.WIDTH(32), .WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_mdop_i(id_mdop), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .flush_i(flush), .mdu_busy_i(mdu_busy), .mdu_hi_i(mdu_hi), .mdu_lo_i(mdu_lo),
    .mdu_d1_o(mdu_d1), .mdu_d2_o(mdu_d2), .mdu_op_o(mdu_op), .mdu_start_o(mdu_start),
    .mdu_madd_o(mdu_madd), .mdu_we_o(mdu_we), .mdu_hilo_o(mdu_hilo), .stall_o(stall),
    .mf_data_o(mf_data), .mf_valid_o(mf_valid), .timeout_o(timeout)
  );
  int errors = 0, checks = 0;
  // reference model: instruction timeline in absolute cycle numbers
  int          cyc = 0, free_at = 0, arm_cyc = -1, wcnt = 0, n_starts = 0;
  logic [3:0]  k_md;
  logic [31:0] m_d1, m_d2;
  logic        m_tmo;
  // behavioural mdu
  int          bcnt = 0, lat_mul = 3, lat_div = 8;
  bit          rand_lat = 0;
  logic [31:0] hi_r, lo_r;
  // DUT outputs sampled mid-cycle
  logic        s_start, s_we, s_madd, s_hilo, s_stall, s_mfv, s_tmo;
  logic [1:0]  s_op;
  logic [31:0] s_d1, s_d2, s_mfd;
  typedef struct {
    logic v; logic [3:0] md; logic fl; logic [31:0] rs, rt;
    logic e_mfv, e_start, e_we; logic [1:0] e_op; logic e_madd, e_hilo;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget exhausted (cycle %0d)", name, cyc);
  endtask
  function automatic bit is_comp(input logic [3:0] m); return m >= 1 && m <= 5; endfunction
  function automatic bit is_mt(input logic [3:0] m); return m == 6 || m == 7; endfunction
  function automatic bit is_mf(input logic [3:0] m); return m == 8 || m == 9; endfunction
  function automatic logic [1:0] exp_op(input logic [3:0] m);
    return (m == 3) ? 2'd3 : (m == 4) ? 2'd2 : (m == 2) ? 2'd0 : 2'd1;
  endfunction
  task automatic model_reset();
    free_at = 0; arm_cyc = -1; wcnt = 0; m_tmo = 0; m_d1 = 0; m_d2 = 0; k_md = 0;
  endtask
  task automatic set_in(input logic v, input logic [3:0] md, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    id_valid = v; id_mdop = md; id_rs = rs; id_rt = rt; flush = fl;
  endtask
  task automatic tick();
    bit idle, req, e_start, e_we, e_mfv;
    logic [63:0] p;
    longint a, b;
    @(negedge clk);
    s_start = mdu_start; s_we = mdu_we; s_madd = mdu_madd; s_hilo = mdu_hilo; s_stall = stall;
    s_mfv = mf_valid; s_tmo = timeout; s_op = mdu_op; s_d1 = mdu_d1; s_d2 = mdu_d2; s_mfd = mf_data;
    n_starts += int'(s_start);
    idle = cyc >= free_at;
    req = id_valid && !flush;
    e_mfv = req && is_mf(id_mdop) && idle;
    e_start = cyc == arm_cyc && is_comp(k_md);
    e_we = cyc == arm_cyc && is_mt(k_md);
    chk("stall", s_stall, req && id_mdop >= 1 && id_mdop <= 9 && !idle);
    chk("mf_valid", s_mfv, e_mfv);
    chk("mf_data", s_mfd, e_mfv ? (id_mdop == 8 ? mdu_hi : mdu_lo) : 32'h0);
    chk("start", s_start, e_start);
    chk("we", s_we, e_we);
    chk("madd", s_madd, e_start && k_md == 5);
    chk("d1", s_d1, m_d1);
    chk("d2", s_d2, m_d2);
    chk("timeout", s_tmo, m_tmo);
    if (e_start) chk("op", s_op, exp_op(k_md));
    if (e_we) chk("hilo", s_hilo, k_md == 7);
    @(posedge clk);
    if (rst) begin
      model_reset();
      bcnt = 0; hi_r = 0; lo_r = 0;
    end else begin
      if (idle && req && (is_comp(id_mdop) || is_mt(id_mdop))) begin
        arm_cyc = cyc + 1; free_at = INF; wcnt = 0; k_md = id_mdop; m_d1 = id_rs; m_d2 = id_rt;
      end else if (!idle && cyc > arm_cyc) begin
        wcnt++;
        if (wcnt >= 16) m_tmo = 1;
        if (!mdu_busy) free_at = cyc + 1;
      end
      if (s_start) begin
        if (!s_op[1]) begin
          if (s_op[0]) begin
            a = longint'($signed(s_d1)); b = longint'($signed(s_d2)); p = a * b;
          end else p = {32'h0, s_d1} * {32'h0, s_d2};
          if (s_madd) p = p + {hi_r, lo_r};
          {hi_r, lo_r} = p;
        end else if (s_d2 != 0) begin
          if (s_op[0]) begin
            a = longint'($signed(s_d1)); b = longint'($signed(s_d2));
            lo_r = 32'(a / b); hi_r = 32'(a % b);
          end else begin
            lo_r = s_d1 / s_d2; hi_r = s_d1 % s_d2;
          end
        end
        bcnt = rand_lat ? int'($urandom_range(0, s_op[1] ? 10 : 4)) : (s_op[1] ? lat_div : lat_mul);
      end else begin
        if (s_we) begin
          if (s_hilo) lo_r = s_d1; else hi_r = s_d1;
        end
        if (bcnt > 0) bcnt--;
      end
    end
    cyc++;
    #1;
    mdu_busy = bcnt != 0; mdu_hi = hi_r; mdu_lo = lo_r;
  endtask
  task automatic drain();
    int g = 0;
    set_in(0, 0, 0, 0, 0);
    while (cyc < free_at && g < 100) begin tick(); g++; end
    if (g >= 100) bound_fail("drain");
  endtask
  task automatic hold_until_free(output int n);
    int g = 0;
    n = int'(s_stall);
    while (s_stall && g < 60) begin tick(); n += int'(s_stall); g++; end
    if (g >= 60) bound_fail("stall_bound");
  endtask
  initial begin
    int n, base;
    tbl[0]  = '{1, 0,  0, 32'h11, 32'h22, 0, 0, 0, 2'd0, 0, 0};
    tbl[1]  = '{1, 1,  0, 32'hA1, 32'hB1, 0, 1, 0, 2'd1, 0, 0};
    tbl[2]  = '{1, 2,  0, 32'hA2, 32'hB2, 0, 1, 0, 2'd0, 0, 0};
    tbl[3]  = '{1, 3,  0, 32'hA3, 32'h5,  0, 1, 0, 2'd3, 0, 0};
    tbl[4]  = '{1, 4,  0, 32'hA4, 32'h0,  0, 1, 0, 2'd2, 0, 0};
    tbl[5]  = '{1, 5,  0, 32'hA5, 32'hB5, 0, 1, 0, 2'd1, 1, 0};
    tbl[6]  = '{1, 6,  0, 32'hC6, 32'h0,  0, 0, 1, 2'd0, 0, 0};
    tbl[7]  = '{1, 7,  0, 32'hC7, 32'h0,  0, 0, 1, 2'd0, 0, 1};
    tbl[8]  = '{1, 8,  0, 32'h0,  32'h0,  1, 0, 0, 2'd0, 0, 0};
    tbl[9]  = '{1, 9,  0, 32'h0,  32'h0,  1, 0, 0, 2'd0, 0, 0};
    tbl[10] = '{1, 12, 0, 32'hDD, 32'hEE, 0, 0, 0, 2'd0, 0, 0};
    tbl[11] = '{0, 1,  0, 32'hDD, 32'hEE, 0, 0, 0, 2'd0, 0, 0};
    tbl[12] = '{1, 3,  1, 32'hDD, 32'hEE, 0, 0, 0, 2'd0, 0, 0};
    rst = 1; mdu_busy = 0; mdu_hi = 0; mdu_lo = 0; hi_r = 0; lo_r = 0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    tick(); tick();
    chk("reset_start", s_start, 0);
    chk("reset_d1", s_d1, 0);
    chk("reset_op", s_op, 0);
    rst = 0;
    tick();
    for (int i = 0; i < 13; i++) begin
      drain();
      set_in(tbl[i].v, tbl[i].md, tbl[i].rs, tbl[i].rt, tbl[i].fl);
      tick();
      chk($sformatf("tbl%0d_mf_valid", i), s_mfv, tbl[i].e_mfv);
      chk($sformatf("tbl%0d_stall", i), s_stall, 0);
      set_in(0, 0, 0, 0, 0);
      tick();
      chk($sformatf("tbl%0d_start", i), s_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_we", i), s_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_madd", i), s_madd, tbl[i].e_madd);
      if (tbl[i].e_start) chk($sformatf("tbl%0d_op", i), s_op, tbl[i].e_op);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_hilo", i), s_hilo, tbl[i].e_hilo);
      if (tbl[i].e_start || tbl[i].e_we) chk($sformatf("tbl%0d_d1", i), s_d1, tbl[i].rs);
    end
    // MULT then dependent MFLO/MFHI
    drain(); lat_mul = 3;
    set_in(1, 1, 32'hFFFFFFFE, 32'd3, 0); tick();
    chk("t1_accept_stall", s_stall, 0);
    set_in(1, 9, 0, 0, 0); tick();
    chk("t1_start", s_start, 1);
    chk("t1_op", s_op, 2'b01);
    hold_until_free(n);
    chk("t1_stall_cycles", n, 5);
    chk("t1_mflo", s_mfd, 32'hFFFFFFFA);
    set_in(1, 8, 0, 0, 0); tick();
    chk("t1_mfhi", s_mfd, 32'hFFFFFFFF);
    // DIVU 7/2 then MFHI, MFLO
    drain(); lat_div = 8;
    set_in(1, 4, 32'd7, 32'd2, 0); tick();
    set_in(1, 8, 0, 0, 0); tick();
    hold_until_free(n);
    chk("t2_stall_cycles", n, 10);
    chk("t2_mfhi", s_mfd, 32'd1);
    set_in(1, 9, 0, 0, 0); tick();
    chk("t2_mflo", s_mfd, 32'd3);
    // MTLO then MFLO
    drain();
    set_in(1, 7, 32'h12345678, 32'h0, 0); tick();
    set_in(1, 9, 0, 0, 0); tick();
    chk("t3_we", s_we, 1);
    chk("t3_hilo", s_hilo, 1);
    chk("t3_start", s_start, 0);
    hold_until_free(n);
    chk("t3_stall_cycles", n, 2);
    chk("t3_mflo", s_mfd, 32'h12345678);
    // MULTU then DIV back to back
    drain(); base = n_starts;
    set_in(1, 2, 32'd5, 32'd6, 0); tick();
    set_in(1, 3, 32'd100, 32'd7, 0); tick();
    chk("t4_div_stalled", s_stall, 1);
    hold_until_free(n);
    set_in(0, 0, 0, 0, 0); tick();
    chk("t4_div_start", s_start, 1);
    chk("t4_div_op", s_op, 2'b11);
    drain();
    chk("t4_starts", n_starts - base, 2);
    set_in(1, 9, 0, 0, 0); tick();
    chk("t4_quot", s_mfd, 32'd14);
    set_in(1, 8, 0, 0, 0); tick();
    chk("t4_rem", s_mfd, 32'd2);
    // reset in the middle of WAIT
    drain();
    set_in(1, 4, 32'd9, 32'd3, 0); tick();
    set_in(1, 8, 0, 0, 0); tick(); tick(); tick();
    chk("t5_pre_stall", s_stall, 1);
    #3; rst = 1; model_reset();
    #1;
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_d1", mdu_d1, 0);
    chk("t5_rst_op", mdu_op, 0);
    tick();
    rst = 0;
    set_in(0, 0, 0, 0, 0); tick();
    chk("t5_after_stall", s_stall, 0);
    // long busy drives the sticky timeout
    drain(); lat_mul = 20;
    set_in(1, 1, 32'd1, 32'd1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) chk("t6_before", s_tmo, 0);
    end
    tick();
    chk("t6_set", s_tmo, 1);
    drain(); tick();
    chk("t6_sticky", s_tmo, 1);
    #3; rst = 1; model_reset();
    #1;
    chk("t6_rst", timeout, 0);
    tick();
    rst = 0; lat_mul = 3;
    // random traffic; stalled requests are re-presented unchanged
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      if (!s_stall)
        set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
               $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)),
               $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 5)),
               $urandom_range(0, 7) == 0);
      tick();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
